// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_ctrl_pkg;

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    typedef enum logic [2:0] {
        ST_PLL_RST   = S_PLL_RST,
        ST_WAIT_LOCK = S_WAIT_LOCK,
        ST_STABLE    = S_STABLE,
        ST_RUN       = S_RUN,
        ST_FAIL      = S_FAIL
    } state_e;

    // Bits needed to count 0..max(a,b,c)-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int unsigned retry_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the lock sequencer and the PLL / downstream logic.
interface pll_lock_ctrl_if #(
    parameter int unsigned LOSS_W = 8
) ();
    logic              locked;
    logic              pll_areset;
    logic              sys_rst;
    logic              lock_ok;
    logic              fail;
    logic [LOSS_W-1:0] loss_cnt;

    modport master (
        input  locked,
        output pll_areset, sys_rst, lock_ok, fail, loss_cnt
    );

    modport slave (
        output locked,
        input  pll_areset, sys_rst, lock_ok, fail, loss_cnt
    );
endinterface

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// Two-flop synchronizer; both stages clear on the synchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: retries on timeout, releases sys_rst after a stable lock window.
// Optional lock-loss counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYC      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1000,
    parameter int unsigned STABLE_CYC   = 64,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned LOSS_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    pll_lock_ctrl_if.master bus
);
    localparam int unsigned CNT_W = cnt_width(RST_CYC, LOCK_TIMEOUT, STABLE_CYC);
    localparam int unsigned RTY_W = retry_width(MAX_RETRY);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              locked_s;
    logic              pll_areset_q, sys_rst_q, lock_ok_q, fail_q;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.locked),
        .q_o (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retry_q == RTY_W'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                        retry_d = retry_q + RTY_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                // A drop during qualification restarts the lock wait without burning a retry.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and outputs decoded from the next state so they move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_areset_q <= 1'b1;
            sys_rst_q    <= 1'b1;
            lock_ok_q    <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_areset_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sys_rst_q    <= (state_d != ST_RUN);
            lock_ok_q    <= (state_d == ST_RUN);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    assign bus.pll_areset = pll_areset_q;
    assign bus.sys_rst    = sys_rst_q;
    assign bus.lock_ok    = lock_ok_q;
    assign bus.fail       = fail_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic              loss_evt;
    logic [LOSS_W-1:0] loss_q;

    assign loss_evt = (state_q == ST_RUN) && !locked_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign bus.loss_cnt = loss_q;
`else
    assign bus.loss_cnt = '0;
`endif
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: start-up, glitchy lock, loss, retry exhaustion, reset, saturation.
module tb_pll_lock_ctrl;
    localparam int unsigned LOSS_W = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pll_lock_ctrl_if #(.LOSS_W(LOSS_W)) bus ();

    pll_lock_ctrl #(
        .RST_CYC      (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYC   (16),
        .MAX_RETRY    (2),
        .LOSS_W       (LOSS_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected lock-loss count after n losses since reset.
    function automatic int exp_loss(input int n);
`ifdef PLL_LOCK_LOSS_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.locked = 1'b0;
        cyc(2);
        n_cmp++; if (bus.pll_areset !== 1'b1) begin n_err++; $display("FAIL reset_areset: got %b want 1", bus.pll_areset); end
        n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL reset_sys_rst: got %b want 1", bus.sys_rst); end
        n_cmp++; if (bus.lock_ok !== 1'b0) begin n_err++; $display("FAIL reset_lock_ok: got %b want 0", bus.lock_ok); end
        n_cmp++; if (bus.fail !== 1'b0) begin n_err++; $display("FAIL reset_fail: got %b want 0", bus.fail); end
        n_cmp++; if (int'(bus.loss_cnt) !== 0) begin n_err++; $display("FAIL reset_loss: got %0d want 0", bus.loss_cnt); end
    endtask

    task automatic test_nominal();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            n_cmp++; if (bus.pll_areset !== 1'b1) begin n_err++; $display("FAIL nom_areset_hi edge %0d: got %b want 1", k, bus.pll_areset); end
        end
        cyc(1);
        n_cmp++; if (bus.pll_areset !== 1'b0) begin n_err++; $display("FAIL nom_areset_lo: got %b want 0", bus.pll_areset); end
        cyc(10);
        bus.locked = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            cyc(1);
            n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL nom_hold edge %0d: got %b want 1", k, bus.sys_rst); end
        end
        cyc(1);
        n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL nom_release: got %b want 0", bus.sys_rst); end
        n_cmp++; if (bus.lock_ok !== 1'b1) begin n_err++; $display("FAIL nom_lock_ok: got %b want 1", bus.lock_ok); end
    endtask

    task automatic test_unstable();
        rst = 1'b1;
        bus.locked = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(4);
        bus.locked = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL unst_hi edge %0d: got %b want 1", k, bus.sys_rst); end
        end
        bus.locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL unst_lo edge %0d: got %b want 1", k, bus.sys_rst); end
        end
        bus.locked = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            cyc(1);
            n_cmp++; if (bus.lock_ok !== 1'b0) begin n_err++; $display("FAIL unst_settle edge %0d: lock_ok got %b want 0", k, bus.lock_ok); end
        end
        cyc(1);
        n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL unst_release: got %b want 0", bus.sys_rst); end
        n_cmp++; if (bus.fail !== 1'b0) begin n_err++; $display("FAIL unst_fail: got %b want 0", bus.fail); end
    endtask

    task automatic test_loss(input int n_losses);
        bus.locked = 1'b0;
        cyc(2);
        n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL loss_early: got %b want 0", bus.sys_rst); end
        cyc(1);
        n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL loss_sys_rst: got %b want 1", bus.sys_rst); end
        n_cmp++; if (bus.lock_ok !== 1'b0) begin n_err++; $display("FAIL loss_lock_ok: got %b want 0", bus.lock_ok); end
        n_cmp++; if (int'(bus.loss_cnt) !== exp_loss(n_losses)) begin n_err++; $display("FAIL loss_cnt: got %0d want %0d", bus.loss_cnt, exp_loss(n_losses)); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (bus.pll_areset !== 1'b1) begin n_err++; $display("FAIL loss_areset_hi %0d: got %b want 1", k, bus.pll_areset); end
            cyc(1);
        end
        n_cmp++; if (bus.pll_areset !== 1'b0) begin n_err++; $display("FAIL loss_areset_lo: got %b want 0", bus.pll_areset); end
        bus.locked = 1'b1;
        cyc(18);
        n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL relock_hold: got %b want 1", bus.sys_rst); end
        cyc(1);
        n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL relock_release: got %b want 0", bus.sys_rst); end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        cyc(1);
        n_cmp++; if (bus.pll_areset !== 1'b1) begin n_err++; $display("FAIL midrst_areset: got %b want 1", bus.pll_areset); end
        n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL midrst_sys_rst: got %b want 1", bus.sys_rst); end
        n_cmp++; if (int'(bus.loss_cnt) !== 0) begin n_err++; $display("FAIL midrst_loss: got %0d want 0", bus.loss_cnt); end
        rst = 1'b0;
        cyc(20);
        n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL midrst_hold: got %b want 1", bus.sys_rst); end
        cyc(1);
        n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL midrst_release: got %b want 0", bus.sys_rst); end
    endtask

    task automatic test_retry_exhaust();
        logic exp_ar;
        logic exp_fail;
        rst = 1'b1;
        bus.locked = 1'b0;
        cyc(1);
        rst = 1'b0;
        // Three attempts of 4 reset + 100 wait cycles, then FAIL from edge 312 on.
        for (int k = 1; k <= 340; k++) begin
            cyc(1);
            exp_fail = (k >= 312);
            exp_ar   = exp_fail || ((k % 104) < 4);
            n_cmp++; if (bus.pll_areset !== exp_ar) begin n_err++; $display("FAIL retry_areset edge %0d: got %b want %b", k, bus.pll_areset, exp_ar); end
            n_cmp++; if (bus.fail !== exp_fail) begin n_err++; $display("FAIL retry_fail edge %0d: got %b want %b", k, bus.fail, exp_fail); end
            n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL retry_sys_rst edge %0d: got %b want 1", k, bus.sys_rst); end
        end
        rst = 1'b1;
        cyc(1);
        n_cmp++; if (bus.fail !== 1'b0) begin n_err++; $display("FAIL restart_fail: got %b want 0", bus.fail); end
        n_cmp++; if (bus.pll_areset !== 1'b1) begin n_err++; $display("FAIL restart_areset: got %b want 1", bus.pll_areset); end
        rst = 1'b0;
        cyc(4);
        n_cmp++; if (bus.pll_areset !== 1'b0) begin n_err++; $display("FAIL restart_wait: got %b want 0", bus.pll_areset); end
        bus.locked = 1'b1;
        cyc(18);
        n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL restart_hold: got %b want 1", bus.sys_rst); end
        cyc(1);
        n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL restart_release: got %b want 0", bus.sys_rst); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            test_loss(i);
        end
        n_cmp++; if (int'(bus.loss_cnt) !== exp_loss(5)) begin n_err++; $display("FAIL sat_final: got %0d want %0d", bus.loss_cnt, exp_loss(5)); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.locked = 1'b0;
        test_reset();
        test_nominal();
        test_unstable();
        test_loss(1);
        test_reset_mid_run();
        test_retry_exhaust();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
